// File: rtl/dcache_lookup_port_pkg.sv
// ----------------------------------------------------------------------------
// dcache_lookup_port_pkg
// Shared types for the data-cache lookup clients: cache line and byte-enable
// layouts, the lookup FSM state encoding and the default-shaped command record.
// No ports; imported by dcache_lookup_port and onehot_sel users.
// ----------------------------------------------------------------------------
package dcache_lookup_port_pkg;

    localparam int DCACHE_TAG_WIDTH   = 44;
    localparam int DCACHE_LINE_WIDTH  = 64;
    localparam int DCACHE_SET_ASSOC   = 8;
    localparam int DCACHE_ADDR_WIDTH  = 64;
    localparam int DCACHE_TAG_BYTES   = (DCACHE_TAG_WIDTH + 7) / 8;
    localparam int DCACHE_LINE_BYTES  = DCACHE_LINE_WIDTH / 8;

    typedef struct packed {
        logic [DCACHE_TAG_WIDTH-1:0]  tag;
        logic [DCACHE_LINE_WIDTH-1:0] data;
        logic                         valid;
        logic                         dirty;
    } cache_line_t;

    typedef struct packed {
        logic [DCACHE_TAG_BYTES-1:0]  tag;
        logic [DCACHE_LINE_BYTES-1:0] data;
        logic                         valid;
        logic                         dirty;
    } cl_be_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        TAG  = 2'd2,
        RSP  = 2'd3
    } lookup_state_e;

    // Command record in the default cache geometry; clients with other
    // geometries build the same layout from their own parameters.
    typedef struct packed {
        logic                         we;
        logic [DCACHE_ADDR_WIDTH-1:0] addr;
        logic [DCACHE_TAG_WIDTH-1:0]  tag;
        logic [DCACHE_SET_ASSOC-1:0]  way;
        cache_line_t                  wdata;
        cl_be_t                       be;
    } lookup_cmd_t;

endpackage

// File: rtl/dcache_lookup_port_onehot_sel.sv
// ----------------------------------------------------------------------------
// onehot_sel
// Reduces a way vector to its lowest set bit (one-hot) and flags whether more
// than one bit was set. Purely combinational.
//   i_vec     : input vector, N bits
//   o_onehot  : lowest set bit of i_vec as one-hot (0 when i_vec == 0)
//   o_any     : at least one bit set
//   o_multi   : two or more bits set
// ----------------------------------------------------------------------------
module onehot_sel #(
    parameter int N = 8
) (
    input  logic [N-1:0] i_vec,
    output logic [N-1:0] o_onehot,
    output logic         o_any,
    output logic         o_multi
);

    // x & -x isolates the lowest set bit; x & (x-1) clears it, so anything
    // left over means a second bit was set.
    assign o_onehot = i_vec & (~i_vec + N'(1));
    assign o_any    = |i_vec;
    assign o_multi  = |(i_vec & (i_vec - N'(1)));

endmodule

// File: rtl/dcache_lookup_port.sv
// ----------------------------------------------------------------------------
// dcache_lookup_port
// Requester-side client of the data-cache tag/data arbiter. Takes one lookup
// or line-write command at a time, requests the arbiter, presents the compare
// tag the cycle after grant, captures hit vector and way data, and holds a
// single response until the consumer accepts it.
//   clk_i, rst_i          : clock, async active-high reset
//   cmd_*                 : command handshake from the cache controller
//   req_o/gnt_i           : per-way request and grant to/from the arbiter
//   addr_o/we_o/be_o/wdata_o : arbiter command fields, live only in REQ
//   tag_o                 : compare tag, live only in TAG
//   rdata_i/hit_way_i     : way data and hit vector from the arbiter
//   rsp_*                 : buffered response with valid/ready
// ----------------------------------------------------------------------------
module dcache_lookup_port
    import dcache_lookup_port_pkg::*;
#(
    parameter int  ADDR_WIDTH = 64,
    parameter int  TAG_WIDTH  = DCACHE_TAG_WIDTH,
    parameter int  SET_ASSOC  = 8,
    parameter type l_data_t   = cache_line_t,
    parameter type l_be_t     = cl_be_t
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           cmd_valid_i,
    output logic                           cmd_ready_o,
    input  logic                           cmd_we_i,
    input  logic [ADDR_WIDTH-1:0]          cmd_addr_i,
    input  logic [TAG_WIDTH-1:0]           cmd_tag_i,
    input  logic [SET_ASSOC-1:0]           cmd_way_i,
    input  l_data_t                        cmd_wdata_i,
    input  l_be_t                          cmd_be_i,
    output logic [SET_ASSOC-1:0]           req_o,
    input  logic                           gnt_i,
    output logic [ADDR_WIDTH-1:0]          addr_o,
    output logic                           we_o,
    output l_be_t                          be_o,
    output l_data_t                        wdata_o,
    output logic [TAG_WIDTH-1:0]           tag_o,
    input  l_data_t [SET_ASSOC-1:0]        rdata_i,
    input  logic [SET_ASSOC-1:0]           hit_way_i,
    output logic                           rsp_valid_o,
    input  logic                           rsp_ready_i,
    output logic                           rsp_write_o,
    output logic                           rsp_hit_o,
    output logic [SET_ASSOC-1:0]           rsp_way_o,
    output l_data_t                        rsp_data_o,
    output logic                           rsp_multihit_o
);

    // Same layout as lookup_cmd_t but sized by this instance's parameters.
    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [TAG_WIDTH-1:0]  tag;
        logic [SET_ASSOC-1:0]  way;
        l_data_t               wdata;
        l_be_t                 be;
    } cmd_t;

    lookup_state_e         r_state;
    cmd_t                  r_cmd;
    logic                  r_rspWrite;
    logic                  r_rspHit;
    logic [SET_ASSOC-1:0]  r_rspWay;
    l_data_t               r_rspData;
    logic                  r_rspMultihit;

    logic [SET_ASSOC-1:0]  w_reqMask;
    logic                  w_granted;
    logic [SET_ASSOC-1:0]  w_hitOnehot;
    logic                  w_hitAny;
    logic                  w_hitMulti;
    l_data_t               w_selData;

    // A lookup asks every way; a write asks only the ways it will update.
    assign w_reqMask = r_cmd.we ? r_cmd.way : {SET_ASSOC{1'b1}};
    assign w_granted = (r_state == REQ) && (w_reqMask != '0) && gnt_i;

    onehot_sel #(
        .N (SET_ASSOC)
    ) u_hitSel (
        .i_vec    (hit_way_i),
        .o_onehot (w_hitOnehot),
        .o_any    (w_hitAny),
        .o_multi  (w_hitMulti)
    );

    // Way-data mux driven by the one-hot hit selection; yields 0 on a miss.
    always_comb begin
        w_selData = '0;
        for (int w = 0; w < SET_ASSOC; w++) begin
            if (w_hitOnehot[w]) begin
                w_selData = rdata_i[w];
            end
        end
    end

    // Single state machine: registers the command, walks REQ/TAG, captures the
    // response at the end of TAG and clears it again once it is accepted so
    // the response outputs read as zero whenever no response is pending.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= IDLE;
            r_cmd         <= '0;
            r_rspWrite    <= 1'b0;
            r_rspHit      <= 1'b0;
            r_rspWay      <= '0;
            r_rspData     <= '0;
            r_rspMultihit <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        r_cmd.we    <= cmd_we_i;
                        r_cmd.addr  <= cmd_addr_i;
                        r_cmd.tag   <= cmd_tag_i;
                        r_cmd.way   <= cmd_way_i;
                        r_cmd.wdata <= cmd_wdata_i;
                        r_cmd.be    <= cmd_be_i;
                        // A write that targets no way has nothing to ask the
                        // arbiter for, so it is acknowledged straight away.
                        if (cmd_we_i && (cmd_way_i == '0)) begin
                            r_rspWrite <= 1'b1;
                            r_rspHit   <= 1'b0;
                            r_rspWay   <= '0;
                            r_rspData  <= '0;
                            r_rspMultihit <= 1'b0;
                            r_state    <= RSP;
                        end else begin
                            r_state <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (w_granted) begin
                        if (r_cmd.we) begin
                            r_rspWrite    <= 1'b1;
                            r_rspHit      <= 1'b0;
                            r_rspWay      <= '0;
                            r_rspData     <= '0;
                            r_rspMultihit <= 1'b0;
                            r_state       <= RSP;
                        end else begin
                            r_state <= TAG;
                        end
                    end
                end
                TAG: begin
                    r_rspWrite    <= 1'b0;
                    r_rspHit      <= w_hitAny;
                    r_rspWay      <= w_hitOnehot;
                    r_rspData     <= w_selData;
                    r_rspMultihit <= w_hitMulti;
                    r_state       <= RSP;
                end
                RSP: begin
                    if (rsp_ready_i) begin
                        r_rspWrite    <= 1'b0;
                        r_rspHit      <= 1'b0;
                        r_rspWay      <= '0;
                        r_rspData     <= '0;
                        r_rspMultihit <= 1'b0;
                        r_state       <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Arbiter-facing fields are gated by state so they read as zero whenever
    // this port is not actively requesting or comparing.
    assign cmd_ready_o    = (r_state == IDLE);
    assign req_o          = (r_state == REQ) ? w_reqMask   : '0;
    assign addr_o         = (r_state == REQ) ? r_cmd.addr  : '0;
    assign we_o           = (r_state == REQ) ? r_cmd.we    : 1'b0;
    assign be_o           = (r_state == REQ) ? r_cmd.be    : '0;
    assign wdata_o        = (r_state == REQ) ? r_cmd.wdata : '0;
    assign tag_o          = (r_state == TAG) ? r_cmd.tag   : '0;

    assign rsp_valid_o    = (r_state == RSP);
    assign rsp_write_o    = r_rspWrite;
    assign rsp_hit_o      = r_rspHit;
    assign rsp_way_o      = r_rspWay;
    assign rsp_data_o     = r_rspData;
    assign rsp_multihit_o = r_rspMultihit;

endmodule

// File: tb/tb_dcache_lookup_port.sv
// ----------------------------------------------------------------------------
// tb_dcache_lookup_port
// Self-checking bench: a behavioural arbiter/cache model answers the port, a
// transaction model predicts every response, latency and request pattern, and
// a per-cycle compare process checks the DUT against those predictions.
// ----------------------------------------------------------------------------
module tb_dcache_lookup_port;
    import dcache_lookup_port_pkg::*;

    localparam int AW = 64;
    localparam int TW = DCACHE_TAG_WIDTH;
    localparam int NW = 8;

    logic                clk_i = 1'b0;
    logic                rst_i = 1'b0;
    logic                cmd_valid_i = 1'b0;
    logic                cmd_ready_o;
    logic                cmd_we_i = 1'b0;
    logic [AW-1:0]       cmd_addr_i = '0;
    logic [TW-1:0]       cmd_tag_i = '0;
    logic [NW-1:0]       cmd_way_i = '0;
    cache_line_t         cmd_wdata_i = '0;
    cl_be_t              cmd_be_i = '0;
    logic [NW-1:0]       req_o;
    logic                gnt_i = 1'b0;
    logic [AW-1:0]       addr_o;
    logic                we_o;
    cl_be_t              be_o;
    cache_line_t         wdata_o;
    logic [TW-1:0]       tag_o;
    cache_line_t [NW-1:0] rdata_i;
    logic [NW-1:0]       hit_way_i;
    logic                rsp_valid_o;
    logic                rsp_ready_i = 1'b0;
    logic                rsp_write_o;
    logic                rsp_hit_o;
    logic [NW-1:0]       rsp_way_o;
    cache_line_t         rsp_data_o;
    logic                rsp_multihit_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    dcache_lookup_port #(
        .ADDR_WIDTH (AW),
        .TAG_WIDTH  (TW),
        .SET_ASSOC  (NW),
        .l_data_t   (cache_line_t),
        .l_be_t     (cl_be_t)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .cmd_valid_i    (cmd_valid_i),
        .cmd_ready_o    (cmd_ready_o),
        .cmd_we_i       (cmd_we_i),
        .cmd_addr_i     (cmd_addr_i),
        .cmd_tag_i      (cmd_tag_i),
        .cmd_way_i      (cmd_way_i),
        .cmd_wdata_i    (cmd_wdata_i),
        .cmd_be_i       (cmd_be_i),
        .req_o          (req_o),
        .gnt_i          (gnt_i),
        .addr_o         (addr_o),
        .we_o           (we_o),
        .be_o           (be_o),
        .wdata_o        (wdata_o),
        .tag_o          (tag_o),
        .rdata_i        (rdata_i),
        .hit_way_i      (hit_way_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp_write_o    (rsp_write_o),
        .rsp_hit_o      (rsp_hit_o),
        .rsp_way_o      (rsp_way_o),
        .rsp_data_o     (rsp_data_o),
        .rsp_multihit_o (rsp_multihit_o)
    );

    // Cache-set contents held by the arbiter model.
    cache_line_t lines [NW];

    // Arbiter model: every way reports its line, and a way hits when it is
    // valid and its stored tag equals the tag the port presents.
    always_comb begin
        for (int w = 0; w < NW; w++) begin
            rdata_i[w]   = lines[w];
            hit_way_i[w] = lines[w].valid && (lines[w].tag == tag_o);
        end
    end

    // Expectations for the transaction currently in flight.
    logic          busy = 1'b0;
    logic          checkEn = 1'b0;
    logic [NW-1:0] expReq;
    logic [AW-1:0] expAddr;
    logic          expWe;
    cl_be_t        expBe;
    cache_line_t   expWdata;
    logic [TW-1:0] expTag;
    logic          expRspWrite;
    logic          expHit;
    logic          expMulti;
    logic [NW-1:0] expWay;
    cache_line_t   expData;

    // Observations from the most recent transaction, used by literal checks.
    int            obsLat;
    int            obsReqCycles;
    logic [NW-1:0] obsReq;
    logic          obsWrite;
    logic          obsHit;
    logic          obsMulti;
    logic [NW-1:0] obsWay;
    cache_line_t   obsData;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Per-cycle compare against the current transaction's expectations.
    always @(negedge clk_i) begin
        if (checkEn && !rst_i) begin
            checkOutput("cmd_ready", 128'(cmd_ready_o), 128'(!busy));
            if (req_o != '0) begin
                checkOutput("req_mask", 128'(req_o), 128'(expReq));
                checkOutput("req_addr", 128'(addr_o), 128'(expAddr));
                checkOutput("req_we", 128'(we_o), 128'(expWe));
                checkOutput("req_be", 128'(be_o), 128'(expBe));
                checkOutput("req_wdata", 128'(wdata_o), 128'(expWdata));
            end else begin
                checkOutput("idle_arb_fields", 128'({addr_o, we_o, be_o}), 128'(0));
                checkOutput("idle_wdata", 128'(wdata_o), 128'(0));
            end
            if (tag_o != '0) begin
                checkOutput("tag_value", 128'(tag_o), 128'(expTag));
                checkOutput("tag_only_in_tag_phase", 128'({busy, req_o != '0, rsp_valid_o}), 128'(3'b100));
            end
            if (rsp_valid_o) begin
                checkOutput("rsp_while_busy", 128'(busy), 128'(1));
                checkOutput("rsp_write", 128'(rsp_write_o), 128'(expRspWrite));
                checkOutput("rsp_hit", 128'(rsp_hit_o), 128'(expHit));
                checkOutput("rsp_way", 128'(rsp_way_o), 128'(expWay));
                checkOutput("rsp_data", 128'(rsp_data_o), 128'(expData));
                checkOutput("rsp_multihit", 128'(rsp_multihit_o), 128'(expMulti));
            end
            if (!busy) begin
                checkOutput("idle_rsp_valid", 128'(rsp_valid_o), 128'(0));
            end
        end
    end

    function automatic logic [TW-1:0] poolTag(input int idx);
        case (idx)
            0: return TW'(44'h1A);
            1: return TW'(44'h2B);
            2: return TW'(44'h33);
            default: return TW'(44'h4C);
        endcase
    endfunction

    function automatic cache_line_t randLine();
        cache_line_t l;
        logic [63:0] r64;
        r64     = {$urandom(), $urandom()};
        l.tag   = poolTag($urandom_range(0, 3));
        l.data  = r64;
        l.valid = 1'($urandom_range(0, 1));
        l.dirty = 1'($urandom_range(0, 1));
        return l;
    endfunction

    // Asynchronous reset pulse in the middle of a clock phase, then release.
    task automatic pulseReset();
        #2;
        rst_i = 1'b1;
        busy  = 1'b0;
        #1;
        checkOutput("rst_req_drop", 128'(req_o), 128'(0));
        checkOutput("rst_rsp_valid_drop", 128'(rsp_valid_o), 128'(0));
        checkOutput("rst_rsp_cleared", 128'({rsp_write_o, rsp_hit_o, rsp_way_o, rsp_multihit_o}), 128'(0));
        checkOutput("rst_rsp_data_cleared", 128'(rsp_data_o), 128'(0));
        gnt_i       = 1'b0;
        rsp_ready_i = 1'b0;
        cmd_valid_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        checkOutput("post_rst_ready", 128'(cmd_ready_o), 128'(1));
    endtask

    // One command from issue to response acceptance. resetAt: 0 none,
    // 1 pulse reset during the request phase, 2 pulse reset while responding.
    task automatic applyStimulus(input logic we, input logic [AW-1:0] addr, input logic [TW-1:0] tag,
                                 input logic [NW-1:0] way, input cache_line_t wdata, input cl_be_t be,
                                 input int stall, input int rspDelay, input bit overlap, input int resetAt);
        int cycles;
        int reqSeen;
        int cnt;
        int expLat;
        int expReqCycles;
        logic [NW-1:0] hits;

        expAddr  = addr;
        expWe    = we;
        expBe    = be;
        expWdata = wdata;
        expTag   = tag;
        expReq   = we ? way : {NW{1'b1}};
        expWay   = '0;
        expData  = '0;
        if (we) begin
            expRspWrite = 1'b1;
            expHit      = 1'b0;
            expMulti    = 1'b0;
        end else begin
            cnt = 0;
            for (int w = 0; w < NW; w++) begin
                hits[w] = lines[w].valid && (lines[w].tag == tag);
                if (hits[w]) cnt++;
            end
            for (int w = NW - 1; w >= 0; w--) begin
                if (hits[w]) begin
                    expWay    = '0;
                    expWay[w] = 1'b1;
                    expData   = lines[w];
                end
            end
            expRspWrite = 1'b0;
            expHit      = (cnt > 0);
            expMulti    = (cnt > 1);
        end
        if (we && way == '0) begin
            expLat       = 1;
            expReqCycles = 0;
        end else begin
            expLat       = stall + (we ? 2 : 3);
            expReqCycles = stall + 1;
        end

        @(negedge clk_i);
        cmd_valid_i = 1'b1;
        cmd_we_i    = we;
        cmd_addr_i  = addr;
        cmd_tag_i   = tag;
        cmd_way_i   = way;
        cmd_wdata_i = wdata;
        cmd_be_i    = be;
        @(posedge clk_i);
        #1;
        cmd_valid_i = 1'b0;
        cmd_addr_i  = {$urandom(), $urandom()};
        busy        = 1'b1;

        cycles  = 0;
        reqSeen = 0;
        obsReq  = '0;
        while (1) begin
            @(negedge clk_i);
            cycles++;
            if (rsp_valid_o || cycles > 60) break;
            if (req_o != '0) begin
                if (resetAt == 1) begin
                    pulseReset();
                    return;
                end
                obsReq  = req_o;
                gnt_i   = (reqSeen >= stall);
                reqSeen++;
            end else begin
                gnt_i = 1'($urandom_range(0, 1));
            end
        end
        gnt_i = 1'b0;

        if (cycles > 60) begin
            checkOutput("rsp_timeout", 128'(0), 128'(1));
            pulseReset();
            return;
        end
        obsLat       = cycles;
        obsReqCycles = reqSeen;
        obsWrite     = rsp_write_o;
        obsHit       = rsp_hit_o;
        obsMulti     = rsp_multihit_o;
        obsWay       = rsp_way_o;
        obsData      = rsp_data_o;
        checkOutput("latency", 128'(cycles), 128'(expLat));
        checkOutput("req_cycles", 128'(reqSeen), 128'(expReqCycles));

        if (resetAt == 2) begin
            pulseReset();
            return;
        end

        for (int i = 0; i < rspDelay; i++) begin
            rsp_ready_i = 1'b0;
            @(negedge clk_i);
            checkOutput("rsp_held", 128'({rsp_valid_o, cmd_ready_o}), 128'(2'b10));
        end
        rsp_ready_i = 1'b1;
        if (overlap) begin
            cmd_valid_i = 1'b1;
            cmd_we_i    = 1'b0;
        end
        @(posedge clk_i);
        #1;
        rsp_ready_i = 1'b0;
        busy        = 1'b0;
        if (overlap) begin
            checkOutput("no_same_cycle_accept", 128'(cmd_ready_o), 128'(1));
            cmd_valid_i = 1'b0;
        end
    endtask

    initial begin
        cache_line_t   wl;
        cl_be_t        wb;
        logic [AW-1:0] a;
        logic [NW-1:0] wm;
        logic [63:0]   r64;
        bit            wr;

        for (int w = 0; w < NW; w++) lines[w] = '0;

        // Reset state.
        #1 rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        checkOutput("reset_ready", 128'(cmd_ready_o), 128'(1));
        checkOutput("reset_req", 128'(req_o), 128'(0));
        checkOutput("reset_rsp_valid", 128'(rsp_valid_o), 128'(0));
        checkOutput("reset_tag", 128'(tag_o), 128'(0));
        checkOutput("reset_arb", 128'({addr_o, we_o}), 128'(0));
        checkOutput("reset_rsp", 128'({rsp_write_o, rsp_hit_o, rsp_way_o, rsp_multihit_o}), 128'(0));
        rst_i = 1'b0;
        @(negedge clk_i);
        checkEn = 1'b1;

        // Single hit in way 3.
        for (int w = 0; w < NW; w++) begin
            lines[w]       = '0;
            lines[w].tag   = TW'(44'h100 + w);
            lines[w].valid = 1'b1;
        end
        lines[3] = '{tag: TW'(44'h1A), data: 64'hD3D3_0000_1234_5678, valid: 1'b1, dirty: 1'b0};
        applyStimulus(1'b0, 64'h40, TW'(44'h1A), '0, '0, '0, 0, 0, 1'b0, 0);
        checkOutput("lit_hit_lat", 128'(obsLat), 128'(3));
        checkOutput("lit_hit", 128'(obsHit), 128'(1));
        checkOutput("lit_hit_way", 128'(obsWay), 128'(8'h08));
        checkOutput("lit_hit_data", 128'(obsData), 128'({44'h1A, 64'hD3D3_0000_1234_5678, 1'b1, 1'b0}));

        // Miss.
        applyStimulus(1'b0, 64'h80, TW'(44'h2B), '0, '0, '0, 0, 0, 1'b0, 0);
        checkOutput("lit_miss", 128'({obsHit, obsWay, obsMulti}), 128'(0));
        checkOutput("lit_miss_data", 128'(obsData), 128'(0));

        // Grant withheld for four request cycles.
        applyStimulus(1'b0, 64'hC0, TW'(44'h1A), '0, '0, '0, 4, 0, 1'b0, 0);
        checkOutput("lit_stall_lat", 128'(obsLat), 128'(7));
        checkOutput("lit_stall_req_cycles", 128'(obsReqCycles), 128'(5));
        checkOutput("lit_stall_req", 128'(obsReq), 128'(8'hFF));

        // Write to way 2 with full byte enables, then a write to no way.
        wl = '{tag: TW'(44'h55), data: 64'hCAFE_F00D_0000_0001, valid: 1'b1, dirty: 1'b1};
        applyStimulus(1'b1, 64'h100, '0, 8'h04, wl, '1, 0, 0, 1'b0, 0);
        checkOutput("lit_wr_req", 128'(obsReq), 128'(8'h04));
        checkOutput("lit_wr_ack", 128'({obsWrite, obsHit}), 128'(2'b10));
        checkOutput("lit_wr_lat", 128'(obsLat), 128'(2));
        applyStimulus(1'b1, 64'h140, '0, 8'h00, wl, '1, 0, 0, 1'b0, 0);
        checkOutput("lit_wr0_lat", 128'(obsLat), 128'(1));
        checkOutput("lit_wr0_noreq", 128'(obsReqCycles), 128'(0));
        checkOutput("lit_wr0_ack", 128'(obsWrite), 128'(1));

        // Multi-hit on ways 1 and 3, response held for five cycles.
        for (int w = 0; w < NW; w++) lines[w].valid = 1'b0;
        lines[1] = '{tag: TW'(44'h33), data: 64'h1111, valid: 1'b1, dirty: 1'b0};
        lines[3] = '{tag: TW'(44'h33), data: 64'h3333, valid: 1'b1, dirty: 1'b0};
        applyStimulus(1'b0, 64'h180, TW'(44'h33), '0, '0, '0, 0, 5, 1'b1, 0);
        checkOutput("lit_multi", 128'(obsMulti), 128'(1));
        checkOutput("lit_multi_way", 128'(obsWay), 128'(8'h02));
        checkOutput("lit_multi_data", 128'(obsData), 128'({44'h33, 64'h1111, 1'b1, 1'b0}));

        // Reset in the request phase and in the response phase.
        applyStimulus(1'b0, 64'h1C0, TW'(44'h33), '0, '0, '0, 10, 0, 1'b0, 1);
        applyStimulus(1'b0, 64'h200, TW'(44'h33), '0, '0, '0, 0, 0, 1'b0, 2);

        // Randomized traffic.
        for (int n = 0; n < 80; n++) begin
            if (n % 4 == 0) begin
                for (int w = 0; w < NW; w++) lines[w] = randLine();
            end
            r64 = {$urandom(), $urandom()};
            a   = r64;
            wr  = ($urandom_range(0, 9) < 3);
            wm  = ($urandom_range(0, 4) == 0) ? '0 : NW'($urandom());
            r64 = {$urandom(), $urandom()};
            wl  = '{tag: poolTag($urandom_range(0, 3)), data: r64, valid: 1'($urandom()), dirty: 1'($urandom())};
            wb  = cl_be_t'($urandom());
            applyStimulus(wr, a, poolTag($urandom_range(0, 3)), wm, wl, wb,
                          $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 0);
        end

        repeat (2) @(negedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
